// File: rtl/tx_gearbox.sv
// ---------------------------------------------------------------------------
// tx_gearbox
//   Transmit-side 66b -> 32b gearbox for the 64b/66b PCS. It accepts whole
//   66-bit blocks with the sync header in bits [1:0] and emits a continuous
//   32-bit word stream in serial order (bit 0 is sent first, on both sides).
//   The source is throttled with din_ready. At full rate the gearbox takes
//   16 blocks for every 33 output words.
//
// Ports
//   clk         in   1      TX clock, rising edge
//   rst_n       in   1      synchronous active-low reset
//   din         in   DSIZE  66-bit block, din[0] transmitted first
//   din_valid   in   1      din holds a block this cycle
//   din_ready   out  1      block taken this cycle when din_valid && din_ready
//   dout        out  OSIZE  output word, dout[0] transmitted first
//   dout_valid  out  1      dout holds a new word this cycle
//
// tx_gearbox_chk (same file) holds the run-time assertions on the fill count.
// ---------------------------------------------------------------------------
module tx_gearbox #(
  parameter int DSIZE = 66,
  parameter int OSIZE = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [OSIZE-1:0] dout,
  output logic             dout_valid
);

  // The buffer must hold the largest post-shift residue (OSIZE-1 bits)
  // plus one fresh block.
  localparam int BSIZE = OSIZE + DSIZE - 1;
  localparam int CW    = 7;

  logic [BSIZE-1:0] buf_r;
  logic [CW-1:0]    cnt_r;
  logic [OSIZE-1:0] dout_r;
  logic             dout_valid_r;

  logic             out_s;
  logic             take_s;
  logic             din_ready_s;
  logic [BSIZE-1:0] buf_sh_s;
  logic [CW-1:0]    cnt_sh_s;
  logic [BSIZE-1:0] keep_mask_s;
  logic [BSIZE-1:0] buf_nxt_s;
  logic [CW-1:0]    cnt_nxt_s;

  // Ready only looks at the fill count and reset, never at din_valid.
  // Accepting below 2*OSIZE bounds the post-shift residue at OSIZE-1 bits.
  assign din_ready_s = rst_n && (cnt_r < CW'(2 * OSIZE));

  // Drain then append: a word leaves first, and any accepted block lands
  // directly above the bits that are left.
  always_comb begin
    out_s       = (cnt_r >= CW'(OSIZE));
    take_s      = din_valid && din_ready_s;
    buf_sh_s    = buf_r;
    cnt_sh_s    = cnt_r;
    keep_mask_s = {BSIZE{1'b0}};
    buf_nxt_s   = buf_r;
    cnt_nxt_s   = cnt_r;

    if (out_s) begin
      buf_sh_s = buf_r >> OSIZE;
      cnt_sh_s = cnt_r - CW'(OSIZE);
    end else begin
      buf_sh_s = buf_r;
      cnt_sh_s = cnt_r;
    end

    // Stale bits above the fill level are masked off. The new block is
    // OR-ed in there, so only the valid residue may survive.
    keep_mask_s = ~({BSIZE{1'b1}} << cnt_sh_s);

    if (take_s) begin
      buf_nxt_s = (buf_sh_s & keep_mask_s) | (BSIZE'(din) << cnt_sh_s);
      cnt_nxt_s = cnt_sh_s + CW'(DSIZE);
    end else begin
      buf_nxt_s = buf_sh_s;
      cnt_nxt_s = cnt_sh_s;
    end
  end

  // Buffer, fill count and output word registers. The reset clears
  // everything, so any bits already buffered are discarded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_r        <= {BSIZE{1'b0}};
      cnt_r        <= {CW{1'b0}};
      dout_r       <= {OSIZE{1'b0}};
      dout_valid_r <= 1'b0;
    end else begin
      buf_r        <= buf_nxt_s;
      cnt_r        <= cnt_nxt_s;
      dout_valid_r <= out_s;
      if (out_s) begin
        dout_r <= buf_r[OSIZE-1:0];
      end
    end
  end

  assign din_ready  = din_ready_s;
  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;

  tx_gearbox_chk #(
    .OSIZE (OSIZE),
    .DSIZE (DSIZE),
    .CW    (CW)
  ) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .cnt        (cnt_r),
    .din_ready  (din_ready_s),
    .dout_valid (dout_valid_r)
  );

endmodule

// ---------------------------------------------------------------------------
// tx_gearbox_chk
//   Run-time assertions on the gearbox fill state. There is no logic output.
//
// Ports
//   clk         in  1   TX clock
//   rst_n       in  1   synchronous active-low reset
//   cnt         in  CW  fill count of the bit buffer
//   din_ready   in  1   ready as driven to the source
//   dout_valid  in  1   registered output-valid
// ---------------------------------------------------------------------------
module tx_gearbox_chk #(
  parameter int OSIZE = 32,
  parameter int DSIZE = 66,
  parameter int CW    = 7
) (
  input logic          clk,
  input logic          rst_n,
  input logic [CW-1:0] cnt,
  input logic          din_ready,
  input logic          dout_valid
);

  logic          was_out_r;
  logic          was_rst_r;

  // Remembers whether the previous edge emitted a word, so that the
  // dout_valid register can be checked against it.
  always_ff @(posedge clk) begin
    was_out_r <= rst_n && (cnt >= CW'(OSIZE));
    was_rst_r <= !rst_n;
  end

  // The buffer holds OSIZE+DSIZE-1 bits, and ready never goes high while
  // taking a block could overflow it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (cnt <= CW'(OSIZE + DSIZE - 1));
      assert (!din_ready || (cnt < CW'(2 * OSIZE)));
      assert (was_rst_r || (dout_valid == was_out_r));
    end
  end

endmodule

// File: tb/tb_tx_gearbox.sv
module tb_tx_gearbox;

  logic        clk;
  logic        rst_n;
  logic [65:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] dout;
  logic        dout_valid;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain FIFO of bits, oldest first.
  bit          mq[$];
  logic        exp_ready, exp_valid;
  logic [31:0] exp_dout;
  logic        obs_ready, obs_valid;
  logic [31:0] obs_dout;
  logic        took;

  tx_gearbox #(.DSIZE(66), .OSIZE(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle, sample ready before the edge, advance the model,
  // and sample the registered outputs 1 ns after the edge.
  task automatic step(input logic r, input logic v, input logic [65:0] d);
    rst_n     = r;
    din_valid = v;
    din       = d;
    #2;
    obs_ready = din_ready;
    exp_ready = r && (mq.size() < 64);
    took      = 1'b0;
    @(posedge clk);
    if (!r) begin
      mq.delete();
      exp_valid = 1'b0;
      exp_dout  = 32'd0;
    end else begin
      exp_valid = (mq.size() >= 32);
      if (exp_valid) begin
        for (int i = 0; i < 32; i++) exp_dout[i] = mq.pop_front();
      end
      if (v && exp_ready) begin
        for (int i = 0; i < 66; i++) mq.push_back(d[i]);
        took = 1'b1;
      end
    end
    #1;
    obs_valid = dout_valid;
    obs_dout  = dout;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 66'h3_FFFF_FFFF_FFFF_FFFF);
      checks++;
      if (obs_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", obs_ready); end
      checks++;
      if (obs_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", obs_valid); end
      checks++;
      if (obs_dout !== 32'd0) begin errors++; $display("FAIL rst_dout got %h exp 0", obs_dout); end
    end
    // Nothing may have been absorbed during reset, so no word may follow.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 66'd0);
      checks++;
      if (obs_ready !== 1'b1) begin errors++; $display("FAIL rst_after_ready got %b exp 1", obs_ready); end
      checks++;
      if (obs_valid !== 1'b0) begin errors++; $display("FAIL rst_after_valid got %b exp 0", obs_valid); end
    end
  endtask

  task automatic test_single_block();
    logic [65:0] blk;
    logic [31:0] w1, w2;
    int          nwords;
    blk = {64'hFEDCBA9876543210, 2'b10};
    w1  = 32'hD950C842;
    w2  = 32'hFB72EA61;
    step(1'b0, 1'b0, 66'd0);
    step(1'b1, 1'b1, blk);
    checks++;
    if (obs_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", obs_ready); end
    checks++;
    if (obs_valid !== 1'b0) begin errors++; $display("FAIL single_lat got %b exp 0", obs_valid); end
    step(1'b1, 1'b0, 66'd0);
    checks++;
    if (obs_valid !== 1'b1 || obs_dout !== w1) begin
      errors++; $display("FAIL single_w1 got %b/%h exp 1/%h", obs_valid, obs_dout, w1);
    end
    step(1'b1, 1'b0, 66'd0);
    checks++;
    if (obs_valid !== 1'b1 || obs_dout !== w2) begin
      errors++; $display("FAIL single_w2 got %b/%h exp 1/%h", obs_valid, obs_dout, w2);
    end
    // The 2 leftover bits wait: no further word, and dout holds.
    nwords = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 66'd0);
      if (obs_valid) nwords++;
      checks++;
      if (obs_dout !== w2) begin errors++; $display("FAIL single_hold got %h exp %h", obs_dout, w2); end
    end
    checks++;
    if (nwords !== 0) begin errors++; $display("FAIL single_tail got %0d exp 0", nwords); end
  endtask

  task automatic test_stream();
    logic [63:0] pay;
    logic        seen;
    int          lows, accs;
    pay  = 64'h0123_4567_0000_0000;
    seen = 1'b0;
    lows = 0;
    accs = 0;
    step(1'b0, 1'b0, 66'd0);
    for (int c = 0; c < 200; c++) begin
      step(1'b1, 1'b1, {pay, 2'b01});
      if (obs_ready) pay = pay + 64'd1;
      checks++;
      if (obs_ready !== exp_ready) begin errors++; $display("FAIL stream_ready c%0d got %b exp %b", c, obs_ready, exp_ready); end
      checks++;
      if (obs_valid !== exp_valid || obs_dout !== exp_dout) begin
        errors++; $display("FAIL stream_data c%0d got %b/%h exp %b/%h", c, obs_valid, obs_dout, exp_valid, exp_dout);
      end
      if (seen) begin
        checks++;
        if (obs_valid !== 1'b1) begin errors++; $display("FAIL stream_gap c%0d got %b exp 1", c, obs_valid); end
      end
      if (obs_valid === 1'b1) seen = 1'b1;
      if (c >= 100 && c < 133) begin
        if (!obs_ready) lows++;
        else accs++;
      end
    end
    checks++;
    if (lows !== 17) begin errors++; $display("FAIL stream_lows got %0d exp 17", lows); end
    checks++;
    if (accs !== 16) begin errors++; $display("FAIL stream_accs got %0d exp 16", accs); end
  endtask

  task automatic test_random_gaps();
    int          accepted;
    int          cyc;
    logic        v;
    logic [65:0] d;
    accepted = 0;
    cyc      = 0;
    step(1'b0, 1'b0, 66'd0);
    while (accepted < 1000 && cyc < 20000) begin
      v = ($urandom_range(0, 99) < 30);
      d = {32'($urandom), 32'($urandom), 2'($urandom_range(0, 3))};
      step(1'b1, v, d);
      if (v && obs_ready) accepted++;
      cyc++;
      checks++;
      if (obs_ready !== exp_ready) begin errors++; $display("FAIL rand_ready c%0d got %b exp %b", cyc, obs_ready, exp_ready); end
      checks++;
      if (obs_valid !== exp_valid || obs_dout !== exp_dout) begin
        errors++; $display("FAIL rand_data c%0d got %b/%h exp %b/%h", cyc, obs_valid, obs_dout, exp_valid, exp_dout);
      end
    end
    checks++;
    if (accepted < 1000) begin errors++; $display("FAIL rand_budget got %0d exp 1000", accepted); end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 66'd0);
      checks++;
      if (obs_valid !== exp_valid || obs_dout !== exp_dout) begin
        errors++; $display("FAIL rand_drain got %b/%h exp %b/%h", obs_valid, obs_dout, exp_valid, exp_dout);
      end
    end
  endtask

  // Whole blocks keep the fill count even, so 96 is the fullest state
  // that can actually be reached. Reset is applied there.
  task automatic test_reset_full();
    logic [65:0] c_blk;
    int          n;
    c_blk = {64'h1122334455667788, 2'b01};
    n     = 0;
    step(1'b0, 1'b0, 66'd0);
    while (mq.size() != 96 && n < 100) begin
      step(1'b1, 1'b1, {64'hAAAA_5555_0000_0000 + 64'(n), 2'b10});
      n++;
    end
    checks++;
    if (mq.size() != 96) begin errors++; $display("FAIL full_reach got %0d exp 96", mq.size()); end
    step(1'b0, 1'b1, 66'h1_2345_6789_ABCD_EF01);
    checks++;
    if (obs_ready !== 1'b0) begin errors++; $display("FAIL full_rst_ready got %b exp 0", obs_ready); end
    checks++;
    if (obs_valid !== 1'b0 || obs_dout !== 32'd0) begin
      errors++; $display("FAIL full_rst_out got %b/%h exp 0/0", obs_valid, obs_dout);
    end
    step(1'b1, 1'b1, c_blk);
    checks++;
    if (obs_ready !== 1'b1) begin errors++; $display("FAIL full_post_ready got %b exp 1", obs_ready); end
    checks++;
    if (obs_valid !== 1'b0) begin errors++; $display("FAIL full_post_valid got %b exp 0", obs_valid); end
    step(1'b1, 1'b0, 66'd0);
    checks++;
    if (obs_valid !== 1'b1 || obs_dout !== c_blk[31:0]) begin
      errors++; $display("FAIL full_first_word got %b/%h exp 1/%h", obs_valid, obs_dout, c_blk[31:0]);
    end
  endtask

  task automatic test_blocked_block();
    logic [65:0] a_blk, b_blk;
    int          nwords;
    a_blk  = {64'h0F0F_0F0F_1234_5678, 2'b01};
    b_blk  = {64'hCAFE_BABE_DEAD_BEEF, 2'b10};
    nwords = 0;
    step(1'b0, 1'b0, 66'd0);
    step(1'b1, 1'b1, a_blk);
    checks++;
    if (obs_ready !== 1'b1) begin errors++; $display("FAIL blk_a_ready got %b exp 1", obs_ready); end
    // The fill count is 66 here, so B has to wait one cycle.
    step(1'b1, 1'b1, b_blk);
    if (obs_valid) nwords++;
    checks++;
    if (obs_ready !== 1'b0) begin errors++; $display("FAIL blk_b_wait got %b exp 0", obs_ready); end
    step(1'b1, 1'b1, b_blk);
    if (obs_valid) nwords++;
    checks++;
    if (obs_ready !== 1'b1) begin errors++; $display("FAIL blk_b_take got %b exp 1", obs_ready); end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 66'd0);
      if (obs_valid) nwords++;
      checks++;
      if (obs_valid !== exp_valid || obs_dout !== exp_dout) begin
        errors++; $display("FAIL blk_data got %b/%h exp %b/%h", obs_valid, obs_dout, exp_valid, exp_dout);
      end
    end
    // 132 bits give 4 full words, with 4 bits left over.
    checks++;
    if (nwords !== 4) begin errors++; $display("FAIL blk_words got %0d exp 4", nwords); end
  endtask

  initial begin
    rst_n     = 1'b0;
    din_valid = 1'b0;
    din       = 66'd0;
    test_reset();
    test_single_block();
    test_stream();
    test_random_gaps();
    test_reset_full();
    test_blocked_block();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
